// File: rtl/jk_response_checker.sv
// Compares a stream of sampled JK flip-flop q values against a loaded table of expected values.
// Optional build macro CHECK_MASK_EN adds a per-entry compare mask (input load_mask).
module jk_response_checker #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
`ifdef CHECK_MASK_EN
    input  logic [WIDTH-1:0]  load_mask,
`endif
    input  logic              start,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample_data,
    output logic              ready,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] err_index,
    output logic [WIDTH-1:0]  err_expected,
    output logic [WIDTH-1:0]  err_actual
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [WIDTH-1:0]  err_expected_q, err_expected_d;
    logic [WIDTH-1:0]  err_actual_q, err_actual_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [WIDTH-1:0]  exp_word;
    logic              mismatch;

    assign exp_word = mem_q[idx_q];

`ifdef CHECK_MASK_EN
    logic [WIDTH-1:0] mask_q [DEPTH];

    always_ff @(posedge clock) begin
        if (!clear && mem_we) begin
            mask_q[load_addr] <= load_mask;
        end
    end

    assign mismatch = |((sample_data ^ exp_word) & mask_q[idx_q]);
`else
    assign mismatch = (sample_data != exp_word);
`endif

    // Table storage is deliberately not reset so a reload is not needed after clear.
    always_ff @(posedge clock) begin
        if (!clear && mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        err_count_d    = err_count_q;
        err_index_d    = err_index_q;
        err_expected_d = err_expected_q;
        err_actual_d   = err_actual_q;
        mem_we         = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                mem_we = load_en;
                if (start) begin
                    state_d        = RUN;
                    idx_d          = '0;
                    err_count_d    = '0;
                    err_index_d    = '0;
                    err_expected_d = '0;
                    err_actual_d   = '0;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    if (mismatch) begin
                        if (err_count_q != (ADDR_W+1)'(DEPTH)) begin
                            err_count_d = err_count_q + (ADDR_W+1)'(1);
                        end
                        if (err_count_q == '0) begin
                            err_index_d    = idx_q;
                            err_expected_d = exp_word;
                            err_actual_d   = sample_data;
                        end
                    end
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            err_count_q    <= '0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_actual_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            err_count_q    <= err_count_d;
            err_index_q    <= err_index_d;
            err_expected_q <= err_expected_d;
            err_actual_q   <= err_actual_d;
        end
    end

    assign ready        = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign pass         = (state_q == DONE) && (err_count_q == '0);
    assign err_count    = err_count_q;
    assign err_index    = err_index_q;
    assign err_expected = err_expected_q;
    assign err_actual   = err_actual_q;

endmodule

// File: tb/tb_jk_response_checker.sv
// Bench for jk_response_checker: table vectors, directed corner sequences and randomized runs
// checked every cycle against a run-history model.
module tb_jk_response_checker;
  localparam int W = 10;
  localparam int D = 4;
  localparam int A = 2;

  logic         clock;
  logic         clear;
  logic         load_en;
  logic [A-1:0] load_addr;
  logic [W-1:0] load_data;
  logic [W-1:0] load_mask;
  logic         start;
  logic         sample_valid;
  logic [W-1:0] sample_data;
  logic         ready;
  logic         done;
  logic         pass;
  logic [A:0]   err_count;
  logic [A-1:0] err_index;
  logic [W-1:0] err_expected;
  logic [W-1:0] err_actual;

  jk_response_checker #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clock        (clock),
    .clear        (clear),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
`ifdef CHECK_MASK_EN
    .load_mask    (load_mask),
`endif
    .start        (start),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .ready        (ready),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .err_index    (err_index),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // reference model: what the table holds and which samples the current run has accepted
  typedef struct {
    logic [A-1:0] idx;
    logic [W-1:0] e;
    logic [W-1:0] a;
    bit           mis;
  } acc_t;

  logic [W-1:0] tb_mem  [D];
  logic [W-1:0] tb_mask [D];
  acc_t         acc_q[$];
  bit           m_run;
  bit           m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (clear) begin
      m_run  = 0;
      m_done = 0;
      acc_q.delete();
    end else if (m_run) begin
      if (sample_valid) begin
        acc_t r;
        r.idx = A'(acc_q.size());
        r.e   = tb_mem[r.idx];
        r.a   = sample_data;
        r.mis = ((sample_data ^ r.e) & tb_mask[r.idx]) != '0;
        acc_q.push_back(r);
        if (acc_q.size() == D) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else begin
      if (load_en) begin
        tb_mem[load_addr] = load_data;
`ifdef CHECK_MASK_EN
        tb_mask[load_addr] = load_mask;
`endif
      end
      if (start) begin
        m_run  = 1;
        m_done = 0;
        acc_q.delete();
      end
    end
  endtask

  task automatic compare_all();
    int cnt;
    int first;
    cnt   = 0;
    first = -1;
    foreach (acc_q[i]) begin
      if (acc_q[i].mis) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    chk("ready", ready, m_run);
    chk("done", done, m_done);
    chk("pass", pass, m_done && cnt == 0);
    chk("err_count", err_count, cnt);
    chk("err_index", err_index, (first < 0) ? 0 : acc_q[first].idx);
    chk("err_expected", err_expected, (first < 0) ? 0 : acc_q[first].e);
    chk("err_actual", err_actual, (first < 0) ? 0 : acc_q[first].a);
  endtask

  // one clock: DUT and model see the same inputs, outputs compared 1ns after the edge
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  // driver tasks
  task automatic idle_inputs();
    clear        = 0;
    load_en      = 0;
    load_addr    = '0;
    load_data    = '0;
    load_mask    = '1;
    start        = 0;
    sample_valid = 0;
    sample_data  = '0;
  endtask

  task automatic load(input int addr, input logic [W-1:0] data, input logic [W-1:0] mask);
    load_en   = 1;
    load_addr = A'(addr);
    load_data = data;
    load_mask = mask;
    cycle();
    load_en   = 0;
  endtask

  task automatic start_run();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic send(input logic [W-1:0] data);
    sample_valid = 1;
    sample_data  = data;
    cycle();
    sample_valid = 0;
  endtask

  task automatic load_std();
    load(0, 10'b101, '1);
    load(1, 10'b010, '1);
    load(2, 10'b111, '1);
    load(3, 10'b000, '1);
  endtask

  task automatic send_std();
    send(10'b101);
    send(10'b010);
    send(10'b111);
    send(10'b000);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         dn;
    logic         p;
    logic [A:0]   cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    foreach (tb_mask[i]) tb_mask[i] = '1;
    foreach (tb_mem[i])  tb_mem[i]  = '0;
    m_run  = 0;
    m_done = 0;

    vt[0] = '{1'b1, 10'b101, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[1] = '{1'b1, 10'b010, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[2] = '{1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[3] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[4] = '{1'b1, 10'b000, 1'b0, 1'b1, 1'b0, 3'd1};
    vt[5] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 3'd1};

    idle_inputs();
    clear = 1;
    cycle();
    cycle();
    clear = 0;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err_count", err_count, 0);

    // exact match
    load_std();
    start_run();
    chk("run_ready", ready, 1);
    send_std();
    chk("match_done", done, 1);
    chk("match_pass", pass, 1);
    chk("match_count", err_count, 0);

    // single mismatch, table driven (gap between 3rd and 4th sample)
    start_run();
    for (int i = 0; i < 6; i++) begin
      sample_valid = vt[i].v;
      sample_data  = vt[i].d;
      cycle();
      sample_valid = 0;
      chk("vec_ready", ready, vt[i].r);
      chk("vec_done", done, vt[i].dn);
      chk("vec_pass", pass, vt[i].p);
      chk("vec_count", err_count, vt[i].cnt);
    end
    chk("single_index", err_index, 2);
    chk("single_expected", err_expected, 10'h007);
    chk("single_actual", err_actual, 10'h3FF);

    // all mismatch, valid every other cycle
    start_run();
    for (int i = 0; i < D; i++) begin
      chk("gap_not_done", done, 0);
      send(10'h200);
      if (i < D - 1) cycle();
    end
    chk("gap_done", done, 1);
    chk("gap_count", err_count, 4);
    chk("gap_index", err_index, 0);
    chk("gap_expected", err_expected, 10'b101);

    // start and load are ignored while running
    start_run();
    send(10'b101);
    send(10'b010);
    start     = 1;
    load_en   = 1;
    load_addr = 2'd3;
    load_data = 10'h155;
    cycle();
    start     = 0;
    load_en   = 0;
    send(10'b111);
    send(10'b000);
    chk("ignore_pass", pass, 1);

    // reset mid-run keeps the table
    start_run();
    send(10'b101);
    clear = 1;
    cycle();
    clear = 0;
    chk("midrst_ready", ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", err_count, 0);
    start_run();
    send_std();
    chk("midrst_pass", pass, 1);

    // start with a simultaneous load from DONE: the new entry is used by the run
    load_en   = 1;
    load_addr = 2'd0;
    load_data = 10'h2AA;
    start     = 1;
    cycle();
    load_en   = 0;
    start     = 0;
    send(10'h2AA);
    send(10'b010);
    send(10'b111);
    send(10'b000);
    chk("ld_start_pass", pass, 1);
    load(0, 10'b101, '1);

`ifdef CHECK_MASK_EN
    load(1, 10'b010, 10'h001);
    start_run();
    send(10'b101);
    send(10'b011);
    chk("mask_count", err_count, 1);
    send(10'b111);
    send(10'b000);
    chk("mask_fail", pass, 0);
    start_run();
    send(10'b101);
    send(10'b110);
    send(10'b111);
    send(10'b000);
    chk("mask_pass", pass, 1);
`endif

    // randomized runs with stray inputs and occasional clear
    for (int iter = 0; iter < 25; iter++) begin
      for (int a = 0; a < D; a++) begin
        load(a, W'($urandom_range(0, 1023)),
             ($urandom_range(0, 1) == 0) ? '1 : W'($urandom_range(0, 1023)));
      end
      start_run();
      for (int c = 0; c < 60 && m_run; c++) begin
        sample_valid = ($urandom_range(0, 2) != 0);
        sample_data  = ($urandom_range(0, 1) == 0) ? tb_mem[acc_q.size()]
                                                   : W'($urandom_range(0, 1023));
        start        = ($urandom_range(0, 9) == 0);
        load_en      = ($urandom_range(0, 9) == 0);
        load_addr    = A'($urandom_range(0, 3));
        load_data    = W'($urandom_range(0, 1023));
        load_mask    = W'($urandom_range(0, 1023));
        clear        = ($urandom_range(0, 39) == 0);
        cycle();
        idle_inputs();
      end
      if (m_run) chk("run_timeout", 1, 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
